// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared defaults and owner encoding for the ROM arbiter.
package rom_arb_pkg;
  localparam int AW_DEF = 5;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_e;
endpackage

// File: rtl/rom_arb_pick.sv
// rom_arb_pick: one-hot grant select between fetch and load requests.
// Ports: if_req/ld_req requests, ld_pri gives load the win on a conflict,
// gnt[0]=fetch grant, gnt[1]=load grant.
module rom_arb_pick (
  input  logic       if_req,
  input  logic       ld_req,
  input  logic       ld_pri,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[1] = ld_req & (ld_pri | ~if_req);
    gnt[0] = if_req & ~gnt[1];
  end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port (fetch/load) arbiter in front of a combinational ROM.
// Ports: clk, reset_n (async active-low); fetch port if_req/if_addr ->
// if_gnt/if_rvalid/if_rdata/if_err; load port ld_* likewise;
// rom_addr/rom_instr to the ROM. Macro ROM_ARB_RR_EN selects round-robin
// conflict resolution; undefined gives fetch priority with load starvation cap.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_err,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  output logic          ld_err,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_instr
);
  logic [1:0] pick_gnt;
  logic ld_pri;
  logic if_bad;
  logic ld_bad;
  logic [AW-1:0] addr_q;
  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b0) || ((a >> (AW + 2)) != 32'b0);
  endfunction
`ifdef ROM_ARB_RR_EN
  owner_e last;
  assign ld_pri = last == OWN_IF;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last <= OWN_LD;
    else if (if_gnt) last <= OWN_IF;
    else if (ld_gnt) last <= OWN_LD;
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt;
  assign ld_pri = cnt == CW'(STARVE_MAX);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (ld_gnt || !ld_req) cnt <= '0;
    else if (if_gnt) cnt <= cnt + 1'b1;
`endif
  rom_arb_pick u_pick (.if_req(if_req), .ld_req(ld_req), .ld_pri(ld_pri), .gnt(pick_gnt));
  // Grants are gated by reset so nothing is accepted while reset is held.
  always_comb begin
    if_gnt = pick_gnt[0] & reset_n;
    ld_gnt = pick_gnt[1] & reset_n;
    if_bad = bad_addr(if_addr);
    ld_bad = bad_addr(ld_addr);
    rom_addr = if_gnt ? if_addr[AW+1:2] : ld_gnt ? ld_addr[AW+1:2] : addr_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q <= '0;
      if_rvalid <= 1'b0;
      if_rdata <= '0;
      if_err <= 1'b0;
      ld_rvalid <= 1'b0;
      ld_rdata <= '0;
      ld_err <= 1'b0;
    end else begin
      addr_q <= rom_addr;
      if_rvalid <= if_gnt;
      ld_rvalid <= ld_gnt;
      if (if_gnt) begin
        if_rdata <= if_bad ? '0 : rom_instr;
        if_err <= if_bad;
      end
      if (ld_gnt) begin
        ld_rdata <= ld_bad ? '0 : rom_instr;
        ld_err <= ld_bad;
      end
    end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter AW, default 5: ROM word-address width.
REQ-002 Parameter STARVE_MAX, default 4: max consecutive fetch grants while a load waits (fixed-priority mode only).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1  fetch port request; held with if_addr stable until if_gnt.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_gnt  out  1  fetch request accepted this cycle.
REQ-008 if_rvalid  out  1  fetch response valid, one cycle.
REQ-009 if_rdata  out  32  fetch response word.
REQ-010 if_err  out  1  fetch response is an error, qualified by if_rvalid.
REQ-011 ld_req, ld_addr, ld_gnt, ld_rvalid, ld_rdata, ld_err: load port, same directions, widths and meaning as the fetch port.
REQ-012 rom_addr  out  AW  word address to the combinational ROM.
REQ-013 rom_instr  in  32  ROM data for rom_addr, same cycle.

Function
REQ-014 At most one of if_gnt/ld_gnt SHALL be high in any cycle; a grant SHALL only go to a requesting port.
REQ-015 Grants SHALL be combinational from req and registered priority state; one grant per cycle whenever any req is high (no idle cycles).
REQ-016 rom_addr SHALL equal granted port's addr[AW+1:2]; with no grant, rom_addr SHALL hold its last driven value.
REQ-017 Response latency SHALL be exactly one cycle: rvalid high the cycle after gnt, on the granted port only, with rdata captured from rom_instr in the grant cycle.
REQ-018 Error: addr[1:0] != 0 or addr[31:AW+2] != 0 SHALL still be granted; response SHALL give rvalid=1, err=1, rdata=0.
REQ-019 rdata and err SHALL hold their last values when rvalid is low.
REQ-020 Back-to-back: a port requesting every cycle and winning every cycle SHALL get rvalid every cycle.
REQ-021 Single requester SHALL always be granted regardless of priority state.

Reset
REQ-022 While reset_n low: if_gnt=ld_gnt=0, all rvalid=0, rdata=0, err=0, rom_addr=0, starvation counter=0, last-owner=load.
REQ-023 Reset asserted between grant and response SHALL drop the response; no rvalid after reset release for pre-reset grants.
REQ-024 First cycle after release with both requesting SHALL grant fetch.

Configuration
REQ-025 Macro ROM_ARB_RR_EN defined: both-request conflicts SHALL alternate, granting the port not granted most recently (last-owner register); STARVE_MAX unused.
REQ-026 Macro undefined: fetch has fixed priority; counter increments on each fetch grant while ld_req high, clears on any load grant or when ld_req low; when counter == STARVE_MAX and both request, load SHALL be granted.

Structure
REQ-027 Package rom_arb_pkg SHALL hold AW and STARVE_MAX defaults and owner enum typedef (OWN_NONE, OWN_IF, OWN_LD).
REQ-028 Grant selection SHALL be sub-module rom_arb_pick (req pair + priority state in, one-hot grant out); response registers and counters stay in rom_arbiter.

Verification
REQ-029 ROM model word0=32'h3c08dead; if_req=1, if_addr=0 for one cycle -> if_gnt same cycle, next cycle if_rvalid=1, if_rdata=32'h3c08dead, if_err=0.
REQ-030 Both req every cycle, if_addr=0, ld_addr=4 (word1=32'h3508beef), RR build -> grants alternate IF,LD,IF,LD starting IF; rdata per port correct.
REQ-031 Same stimulus, fixed-priority build, STARVE_MAX=4 -> 4 fetch grants, 1 load grant, repeating.
REQ-032 ld_addr=32'h00000006 and separately 32'h00000080 -> ld_gnt, next cycle ld_rvalid=1, ld_err=1, ld_rdata=0.
REQ-033 Grant fetch, assert reset_n=0 before next edge, release -> no if_rvalid ever for that grant; all outputs 0 during reset.
REQ-034 if_req only, 8 consecutive cycles, addresses 0,4,...,28 -> 8 consecutive rvalid pulses, rom_addr 0..7, never ld_gnt.
